// File: rtl/multicycle_lookahead_subtractor.sv
// Multi-cycle subtractor: A - B computed one CHUNK-bit lookahead slice per clock.
// Optional signed-overflow flag enabled by defining SUB_OVERFLOW_EN.
module multicycle_lookahead_subtractor #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_minuend,
  input  logic [WIDTH-1:0] i_subtrahend,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_borrow,
  output logic             o_zero,
  output logic             o_overflow
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] nb_q, nb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             carry_q, carry_d;
  logic             borrow_q, borrow_d;
  logic             zero_q, zero_d;
`ifdef SUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic [CHUNK-1:0] sliceA;
  logic [CHUNK-1:0] sliceB;
  logic [CHUNK-1:0] sliceG;
  logic [CHUNK-1:0] sliceP;
  logic [CHUNK-1:0] sliceSum;
  logic             carryChain;
  logic [WIDTH-1:0] diffMerged;
  logic             lastSlice;

  // Operands shift right each cycle, so the active slice always sits in the low CHUNK bits.
  always_comb begin
    sliceA     = a_q[CHUNK-1:0];
    sliceB     = nb_q[CHUNK-1:0];
    sliceG     = sliceA & sliceB;
    sliceP     = sliceA | sliceB;
    sliceSum   = '0;
    carryChain = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      sliceSum[i] = sliceA[i] ^ sliceB[i] ^ carryChain;
      carryChain  = sliceG[i] | (sliceP[i] & carryChain);
    end
  end

  // Result fills from the top; after N slices slice 0 has reached the LSBs.
  always_comb begin
    diffMerged                   = diff_q >> CHUNK;
    diffMerged[WIDTH-1 -: CHUNK] = sliceSum;
  end

  assign lastSlice = (k_q == KW'(N - 1));

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    a_d      = a_q;
    nb_d     = nb_q;
    diff_d   = diff_q;
    carry_d  = carry_q;
    borrow_d = borrow_q;
    zero_d   = zero_q;
`ifdef SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_valid) begin
          a_d     = i_minuend;
          nb_d    = ~i_subtrahend;
          carry_d = 1'b1;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> CHUNK;
        nb_d    = nb_q >> CHUNK;
        diff_d  = diffMerged;
        carry_d = carryChain;
        k_d     = k_q + KW'(1);
        if (lastSlice) begin
          k_d      = '0;
          state_d  = DONE;
          borrow_d = ~carryChain;
          zero_d   = (diffMerged == '0);
`ifdef SUB_OVERFLOW_EN
          // The top slice holds the operand MSBs; B's MSB is the inverse of the stored ~B.
          ovf_d    = (sliceA[CHUNK-1] != ~sliceB[CHUNK-1]) &&
                     (sliceSum[CHUNK-1] != sliceA[CHUNK-1]);
`endif
        end
      end
      DONE: begin
        if (i_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      nb_q     <= '0;
      diff_q   <= '0;
      carry_q  <= 1'b0;
      borrow_q <= 1'b0;
      zero_q   <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      a_q      <= a_d;
      nb_q     <= nb_d;
      diff_q   <= diff_d;
      carry_q  <= carry_d;
      borrow_q <= borrow_d;
      zero_q   <= zero_d;
`ifdef SUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign o_ready    = (state_q == IDLE);
  assign o_valid    = (state_q == DONE);
  assign o_diff     = diff_q;
  assign o_borrow   = borrow_q;
  assign o_zero     = zero_q;
`ifdef SUB_OVERFLOW_EN
  assign o_overflow = ovf_q;
`else
  assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_lookahead_subtractor.sv
// Randomized and directed bench for multicycle_lookahead_subtractor against an arithmetic model.
module tb_multicycle_lookahead_subtractor;

`ifdef SUB_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid;
  logic        outReady;
  logic [31:0] minuend;
  logic [31:0] subtrahend;
  logic        outValid;
  logic        inReady;
  logic [31:0] diff;
  logic        borrow;
  logic        zero;
  logic        overflow;

  int compared   = 0;
  int mismatched = 0;

  multicycle_lookahead_subtractor #(.WIDTH(32), .CHUNK(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rstN),
    .i_valid      (inValid),
    .o_ready      (outReady),
    .i_minuend    (minuend),
    .i_subtrahend (subtrahend),
    .o_valid      (outValid),
    .i_ready      (inReady),
    .o_diff       (diff),
    .o_borrow     (borrow),
    .o_zero       (zero),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time expired, required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic modelOvf(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] d;
    d = a - b;
    return OVF_EN && (a[31] != b[31]) && (d[31] != a[31]);
  endfunction

  // Accepts one operation from IDLE and waits (bounded) for o_valid; optionally releases the result.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit releaseResult,
                        output logic [31:0] d, output logic bo, output logic ze,
                        output logic ov, output int lat);
    inValid    = 1'b1;
    minuend    = a;
    subtrahend = b;
    @(posedge clk); #1;
    inValid = 1'b0;
    lat = 0;
    while (outValid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    d  = diff;
    bo = borrow;
    ze = zero;
    ov = overflow;
    if (releaseResult) begin
      inReady = 1'b1;
      @(posedge clk); #1;
      inReady = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0; inValid = 1'b0; inReady = 1'b0; minuend = '0; subtrahend = '0;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (outValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", outValid); end
    compared++; if (outReady !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_ready: got %b expected 1", outReady); end
    compared++; if (diff !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_diff: got %h expected 0", diff); end
    compared++; if ({borrow, zero, overflow} !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_flags: got %b expected 000", {borrow, zero, overflow}); end
    rstN = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] d;
    logic bo, ze, ov;
    int lat;
    run_op(32'h00000100, 32'h00000001, 1'b1, d, bo, ze, ov, lat);
    compared++; if (lat !== 4) begin mismatched++; $display("[TB] FAIL cross_latency: got %0d expected 4", lat); end
    compared++; if (d !== 32'h000000FF) begin mismatched++; $display("[TB] FAIL cross_diff: got %h expected 000000ff", d); end
    compared++; if ({bo, ze} !== 2'b00) begin mismatched++; $display("[TB] FAIL cross_flags: got %b expected 00", {bo, ze}); end
    compared++; if (outReady !== 1'b1) begin mismatched++; $display("[TB] FAIL cross_ready_after: got %b expected 1", outReady); end

    run_op(32'h00000003, 32'h00000005, 1'b1, d, bo, ze, ov, lat);
    compared++; if (d !== 32'hFFFFFFFE) begin mismatched++; $display("[TB] FAIL neg_diff: got %h expected fffffffe", d); end
    compared++; if ({bo, ze} !== 2'b10) begin mismatched++; $display("[TB] FAIL neg_flags: got %b expected 10", {bo, ze}); end

    run_op(32'h12345678, 32'h12345678, 1'b1, d, bo, ze, ov, lat);
    compared++; if (d !== 32'h0) begin mismatched++; $display("[TB] FAIL equal_diff: got %h expected 0", d); end
    compared++; if ({bo, ze} !== 2'b01) begin mismatched++; $display("[TB] FAIL equal_flags: got %b expected 01", {bo, ze}); end

    run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, d, bo, ze, ov, lat);
    compared++; if (d !== 32'h80000000) begin mismatched++; $display("[TB] FAIL ovf_diff: got %h expected 80000000", d); end
    compared++; if (bo !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_borrow: got %b expected 1", bo); end
    compared++; if (ov !== OVF_EN) begin mismatched++; $display("[TB] FAIL ovf_flag: got %b expected %b", ov, OVF_EN); end
  endtask

  task automatic test_random();
    logic [31:0] a, b, d;
    logic bo, ze, ov;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = a;
        1: b = a + $urandom_range(0, 3) - 1;
        default: b = $urandom;
      endcase
      run_op(a, b, 1'b1, d, bo, ze, ov, lat);
      compared++; if (lat !== 4) begin mismatched++; $display("[TB] FAIL rand_latency: got %0d expected 4", lat); end
      compared++; if (d !== a - b) begin mismatched++; $display("[TB] FAIL rand_diff: a=%h b=%h got %h expected %h", a, b, d, a - b); end
      compared++; if (bo !== (a < b)) begin mismatched++; $display("[TB] FAIL rand_borrow: a=%h b=%h got %b expected %b", a, b, bo, a < b); end
      compared++; if (ze !== (a == b)) begin mismatched++; $display("[TB] FAIL rand_zero: a=%h b=%h got %b expected %b", a, b, ze, a == b); end
      compared++; if (ov !== modelOvf(a, b)) begin mismatched++; $display("[TB] FAIL rand_ovf: a=%h b=%h got %b expected %b", a, b, ov, modelOvf(a, b)); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b, d;
    logic bo, ze, ov;
    int lat;
    a = $urandom;
    b = $urandom;
    run_op(a, b, 1'b0, d, bo, ze, ov, lat);
    compared++; if (d !== a - b) begin mismatched++; $display("[TB] FAIL bp_diff: got %h expected %h", d, a - b); end
    for (int i = 0; i < 10; i++) begin
      inValid    = 1'b1;
      minuend    = $urandom;
      subtrahend = $urandom;
      @(posedge clk); #1;
      compared++; if (diff !== a - b) begin mismatched++; $display("[TB] FAIL bp_hold_diff: got %h expected %h", diff, a - b); end
      compared++; if ({outValid, outReady} !== 2'b10) begin mismatched++; $display("[TB] FAIL bp_hold_handshake: got %b expected 10", {outValid, outReady}); end
      compared++; if ({borrow, zero, overflow} !== {a < b, a == b, modelOvf(a, b)}) begin mismatched++; $display("[TB] FAIL bp_hold_flags: got %b expected %b", {borrow, zero, overflow}, {a < b, a == b, modelOvf(a, b)}); end
    end
    inValid = 1'b0;
    inReady = 1'b1;
    @(posedge clk); #1;
    inReady = 1'b0;
    compared++; if ({outValid, outReady} !== 2'b01) begin mismatched++; $display("[TB] FAIL bp_release: got %b expected 01", {outValid, outReady}); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a, b;
    int waitCycles;
    a = $urandom;
    b = $urandom;
    inValid = 1'b1; inReady = 1'b1; minuend = a; subtrahend = b;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(posedge clk); #1;
      compared++; if (outValid !== ((cyc % 6) == 4)) begin mismatched++; $display("[TB] FAIL b2b_valid: cycle %0d got %b expected %b", cyc, outValid, (cyc % 6) == 4); end
      compared++; if (outReady !== ((cyc % 6) == 5)) begin mismatched++; $display("[TB] FAIL b2b_ready: cycle %0d got %b expected %b", cyc, outReady, (cyc % 6) == 5); end
      if ((cyc % 6) == 4) begin
        compared++; if (diff !== a - b) begin mismatched++; $display("[TB] FAIL b2b_diff: got %h expected %h", diff, a - b); end
      end
    end
    inValid = 1'b0;
    waitCycles = 0;
    while (outReady !== 1'b1 && waitCycles < 20) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    inReady = 1'b0;
    compared++; if (outReady !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_drain: got %b expected 1", outReady); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    logic bo, ze, ov;
    int lat;
    bit sawValid;
    inValid = 1'b1; minuend = $urandom; subtrahend = $urandom;
    @(posedge clk); #1;
    inValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstN = 1'b0;
    @(posedge clk); #1;
    rstN = 1'b1;
    compared++; if (diff !== 32'h0) begin mismatched++; $display("[TB] FAIL mid_reset_diff: got %h expected 0", diff); end
    compared++; if ({borrow, zero, overflow} !== 3'b000) begin mismatched++; $display("[TB] FAIL mid_reset_flags: got %b expected 000", {borrow, zero, overflow}); end
    sawValid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (outValid !== 1'b0) sawValid = 1'b1;
    end
    compared++; if (sawValid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_reset_no_valid: got %b expected 0", sawValid); end
    compared++; if (outReady !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_reset_ready: got %b expected 1", outReady); end
    run_op(32'd10, 32'd4, 1'b1, d, bo, ze, ov, lat);
    compared++; if (d !== 32'd6) begin mismatched++; $display("[TB] FAIL mid_reset_followup: got %h expected 6", d); end
    compared++; if (lat !== 4) begin mismatched++; $display("[TB] FAIL mid_reset_latency: got %0d expected 4", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_lookahead_subtractor.md
# multicycle_lookahead_subtractor

Multi-cycle two's-complement subtractor computing `o_diff = i_minuend - i_subtrahend` one CHUNK-bit slice per clock. Each slice uses generate/propagate carry-lookahead internally, and the carry ripples between slices through a register. The block supplies the subtract and compare path for the posit datapath (exponent/regime differencing, fraction alignment). Valid/ready handshakes on both sides let it sit between pipeline stages.

## Interface
- `WIDTH`, 32, operand and result width; must be a multiple of `CHUNK`.
- `CHUNK`, 8, bits processed per cycle; N = WIDTH/CHUNK cycles per operation.
- `i_clk` input 1: clock; all logic on the rising edge.
- `i_rst_n` input 1: reset, synchronous, active-low.
- `i_valid` input 1: operands valid.
- `o_ready` output 1: block can accept operands; high only in IDLE.
- `i_minuend` input WIDTH: A.
- `i_subtrahend` input WIDTH: B.
- `o_valid` output 1: result valid.
- `i_ready` input 1: downstream accepts the result.
- `o_diff` output WIDTH: A - B, modulo 2^WIDTH.
- `o_borrow` output 1: 1 when A < B, unsigned.
- `o_zero` output 1: 1 when `o_diff` == 0.
- `o_overflow` output 1: signed overflow flag; see Configuration.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - `o_ready`=1.
  - When `i_valid && o_ready`: register A, register ~B, set carry register to 1, set chunk counter k=0, go to RUN.
- **RUN:** each cycle computes slice k.
  - Bits [k*CHUNK +: CHUNK] = A_k + ~B_k + carry.
  - Within the slice: G=a&b, P=a|b, c[i+1]=G[i]|(P[i]&c[i]).
  - Store the sum slice and the slice carry-out; k++.
  - After slice N-1: go to DONE and register the flags.
  - `o_ready`=0 and `i_valid` is ignored.
- **DONE:**
  - `o_valid`=1.
  - `o_diff` and all flags are held stable while `i_ready`=0.
  - On `o_valid && i_ready`: go to IDLE. No same-cycle re-accept.
- **Flags:**
  - `o_borrow` = ~(final carry-out).
  - `o_zero` = (diff == 0).
- **Arithmetic rules:** all widths are exact; no sign extension; wrap-around modulo 2^WIDTH.
- **Reset (`i_rst_n`=0 at a clock edge):**
  - State goes to IDLE and k=0.
  - `o_valid`=0, `o_diff`=0, `o_borrow`=0, `o_zero`=0, `o_overflow`=0, `o_ready`=1.
  - An in-flight operation is discarded and never produces `o_valid`.

## Timing
- Accept edge at cycle 0. RUN edges at cycles 1..N. `o_valid` high from cycle N onward (N=4 for defaults).
- Minimum spacing between accepts is N+2 cycles.
- `o_ready` and `o_valid` are decoded from registered state only. There is no combinational path from `i_valid` or `i_ready` to any output.
- The critical path is one CHUNK-bit lookahead plus the carry-register mux.

## Configuration
- **Macro:** `SUB_OVERFLOW_EN`.
- **Defined:** `o_overflow` = (A[MSB] != B[MSB]) && (D[MSB] != A[MSB]). It is registered in DONE with the other flags.
- **Undefined:** `o_overflow` is tied to 0. The port remains present, and no overflow logic is synthesized.

## Test plan
All scenarios use WIDTH=32, CHUNK=8.
- **Cross-slice borrow:** A=0x00000100, B=0x00000001 -> `o_diff`=0x000000FF, `o_borrow`=0, `o_zero`=0. `o_valid` rises 4 cycles after the accept edge.
- **Negative result:** A=0x00000003, B=0x00000005 -> `o_diff`=0xFFFFFFFE, `o_borrow`=1, `o_zero`=0.
- **Equal operands:** A=B=0x12345678 -> `o_diff`=0, `o_zero`=1, `o_borrow`=0.
- **Backpressure:** hold `i_ready`=0 for 10 cycles in DONE while driving `i_valid`=1 with new operands -> `o_diff` and flags unchanged, `o_ready`=0, no accept. Raise `i_ready` -> `o_ready`=1 on the next cycle.
- **Overflow, with `SUB_OVERFLOW_EN`:** A=0x7FFFFFFF, B=0xFFFFFFFF -> `o_diff`=0x80000000, `o_overflow`=1, `o_borrow`=1. Without the macro -> `o_overflow`=0.
- **Mid-operation reset:** pull `i_rst_n` low after 2 RUN cycles -> `o_valid` never asserts and `o_ready`=1 after release. A following op A=10, B=4 returns `o_diff`=6.
